// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between pipeline write-back (A, priority)
// and a FIFO-buffered long-latency unit (B), with a one-slot starvation stall.
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 5,
  parameter int DW           = 32
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   a_we,
  input  logic [AW-1:0]          a_reg,
  input  logic [DW-1:0]          a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [AW-1:0]          b_reg,
  input  logic [DW-1:0]          b_data,
  output logic                   a_stall,
  output logic                   regWrite,
  output logic [AW-1:0]          writeReg,
  output logic [DW-1:0]          writeData,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ARB, STALL} state_t;

  state_t          state;
  logic [SW-1:0]   starveCnt;
  logic [SW-1:0]   starveNext;
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;
  logic [AW-1:0]   fifoReg  [DEPTH];
  logic [DW-1:0]   fifoData [DEPTH];

  logic aReq;
  logic push;
  logic pop;
  logic fifoEmpty;
  logic issueA;
  logic issueB;

  assign aReq      = a_we && (a_reg != '0);
  assign fifoEmpty = (fifo_cnt == '0);
  assign b_ready   = (fifo_cnt < CW'(DEPTH));
  // Register-0 B requests handshake normally but are never queued.
  assign push      = b_valid && b_ready && (b_reg != '0);
  assign issueA    = (state == ARB) && aReq;
  assign issueB    = !fifoEmpty && ((state == STALL) || !aReq);
  assign pop       = issueB;
  assign a_stall   = (state == STALL);

  always_comb begin
    starveNext = starveCnt;
    if (issueB || fifoEmpty) begin
      starveNext = '0;
    end else if (issueA && (starveCnt < SW'(STARVE_LIMIT))) begin
      starveNext = starveCnt + SW'(1);
    end
  end

  // Control and write-port registers
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      starveCnt <= '0;
      fifo_cnt  <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      err       <= 1'b0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      starveCnt <= starveNext;

      if (state == STALL) begin
        state <= ARB;
        if (aReq) begin
          err <= 1'b1;
        end
      end else if (issueA && !fifoEmpty && (starveNext == SW'(STARVE_LIMIT))) begin
        state <= STALL;
      end

      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      regWrite <= issueA || issueB;
      if (issueA) begin
        writeReg  <= a_reg;
        writeData <= a_data;
      end else if (issueB) begin
        writeReg  <= fifoReg[rdPtr];
        writeData <= fifoData[rdPtr];
      end
    end
  end

  // FIFO storage is data only and needs no reset
  always_ff @(posedge clock_in) begin
    if (push) begin
      fifoReg[wrPtr]  <= b_reg;
      fifoData[wrPtr] <= b_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued as stimulus is
// driven and compared in order whenever the write port fires.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        aWe;
  logic [4:0]  aReg;
  logic [31:0] aData;
  logic        bValid;
  logic        bReady;
  logic [4:0]  bReg;
  logic [31:0] bData;
  logic        aStall;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [1:0]  fifoCnt;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  logic [4:0]  expReg[$];
  logic [31:0] expData[$];
  logic [31:0] rf[32];

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .AW(5), .DW(32)) dut (
    .clock_in (clk),
    .reset    (rst_n),
    .a_we     (aWe),
    .a_reg    (aReg),
    .a_data   (aData),
    .b_valid  (bValid),
    .b_ready  (bReady),
    .b_reg    (bReg),
    .b_data   (bData),
    .a_stall  (aStall),
    .regWrite (regWrite),
    .writeReg (writeReg),
    .writeData(writeData),
    .fifo_cnt (fifoCnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model fed from the DUT write port
  always @(posedge clk) begin
    if (regWrite) rf[writeReg] <= writeData;
  end

  // Every cycle with regWrite high is one issue; it must match the queue head.
  always @(negedge clk) begin
    if (regWrite) begin
      vectors++;
      assert (expReg.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed reg %0d data %h required no write", writeReg, writeData);
      end
      if (expReg.size() != 0) begin
        logic [4:0]  r;
        logic [31:0] d;
        r = expReg.pop_front();
        d = expData.pop_front();
        vectors++;
        assert ((writeReg === r) && (writeData === d)) else begin
          miscompares++;
          $error("FAIL write_port: observed reg %0d data %h required reg %0d data %h", writeReg, writeData, r, d);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] r, input logic [31:0] d);
    expReg.push_back(r);
    expData.push_back(d);
  endtask

  task automatic setA(input logic we, input logic [4:0] r, input logic [31:0] d);
    aWe = we; aReg = r; aData = d;
  endtask

  task automatic setB(input logic v, input logic [4:0] r, input logic [31:0] d);
    bValid = v; bReg = r; bData = d;
  endtask

  initial begin
    rst_n = 1'b0;
    setA(1'b0, 5'd0, 32'h0);
    setB(1'b0, 5'd0, 32'h0);
    step();
    step();
    check("rst_regWrite", regWrite, 0);
    check("rst_writeReg", writeReg, 0);
    check("rst_writeData", writeData, 0);
    check("rst_fifo_cnt", fifoCnt, 0);
    check("rst_b_ready", bReady, 1);
    check("rst_a_stall", aStall, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // Single write-back write
    setA(1'b1, 5'd21, 32'hFFFF0000);
    expectWrite(5'd21, 32'hFFFF0000);
    step();
    setA(1'b0, 5'd0, 32'h0);
    check("a_regWrite", regWrite, 1);
    step();
    check("rf21_readback", rf[21], 32'hFFFF0000);

    // A and B on the same edge: A first, B next
    setA(1'b1, 5'd10, 32'h0000FFFF);
    setB(1'b1, 5'd21, 32'h12345678);
    expectWrite(5'd10, 32'h0000FFFF);
    expectWrite(5'd21, 32'h12345678);
    step();
    setA(1'b0, 5'd0, 32'h0);
    setB(1'b0, 5'd0, 32'h0);
    check("ab_cnt1", fifoCnt, 1);
    step();
    check("ab_cnt0", fifoCnt, 0);
    step();

    // Continuous A, three B pushes: FIFO fills, starvation stall drains it
    setA(1'b1, 5'd1, 32'hA1);
    setB(1'b1, 5'd6, 32'hB0);
    expectWrite(5'd1, 32'hA1);
    step();
    check("fill_cnt1", fifoCnt, 1);
    setA(1'b1, 5'd1, 32'hA2);
    setB(1'b1, 5'd7, 32'hB1);
    expectWrite(5'd1, 32'hA2);
    step();
    check("fill_cnt2", fifoCnt, 2);
    check("fill_b_ready0", bReady, 0);
    setB(1'b1, 5'd8, 32'hB2);
    for (int i = 3; i <= 5; i++) begin
      setA(1'b1, 5'd1, 32'hA0 + 32'(i));
      expectWrite(5'd1, 32'hA0 + 32'(i));
      step();
      check("full_held_cnt", fifoCnt, 2);
    end
    check("starve_a_stall1", aStall, 1);
    setA(1'b0, 5'd0, 32'h0);
    expectWrite(5'd6, 32'hB0);
    step();
    check("after_stall_a_stall0", aStall, 0);
    check("after_stall_cnt1", fifoCnt, 1);
    check("after_stall_b_ready1", bReady, 1);
    setA(1'b1, 5'd1, 32'hA6);
    expectWrite(5'd1, 32'hA6);
    step();
    check("third_accepted_cnt2", fifoCnt, 2);
    setA(1'b0, 5'd0, 32'h0);
    setB(1'b0, 5'd0, 32'h0);
    expectWrite(5'd7, 32'hB1);
    expectWrite(5'd8, 32'hB2);
    step();
    step();
    check("drained_cnt0", fifoCnt, 0);
    step();

    // Starvation with A asserted during the stall cycle: dropped, err sets
    check("pre_err0", err, 0);
    setA(1'b1, 5'd2, 32'hC1);
    setB(1'b1, 5'd9, 32'hD0);
    expectWrite(5'd2, 32'hC1);
    step();
    setB(1'b0, 5'd0, 32'h0);
    for (int i = 2; i <= 5; i++) begin
      setA(1'b1, 5'd2, 32'hC0 + 32'(i));
      expectWrite(5'd2, 32'hC0 + 32'(i));
      step();
    end
    check("stall2_a_stall1", aStall, 1);
    setA(1'b1, 5'd3, 32'hDEAD);
    expectWrite(5'd9, 32'hD0);
    step();
    check("lost_write_err1", err, 1);
    check("stall2_a_stall0", aStall, 0);
    setA(1'b1, 5'd2, 32'hC6);
    expectWrite(5'd2, 32'hC6);
    step();
    setA(1'b0, 5'd0, 32'h0);
    step();
    step();
    check("rf3_untouched", rf[3], 32'h0);

    // Register 0: A ignored, B drained; B to reg 0 accepted but not queued
    setA(1'b1, 5'd0, 32'hEEEE);
    setB(1'b1, 5'd5, 32'h55);
    expectWrite(5'd5, 32'h55);
    step();
    check("r0_cnt1", fifoCnt, 1);
    setB(1'b0, 5'd0, 32'h0);
    step();
    check("r0_cnt0", fifoCnt, 0);
    setA(1'b0, 5'd0, 32'h0);
    setB(1'b1, 5'd0, 32'h0BAD);
    step();
    check("b_reg0_cnt", fifoCnt, 0);
    check("b_reg0_ready", bReady, 1);
    setB(1'b0, 5'd0, 32'h0);
    step();
    step();

    // Asynchronous reset with two queued B entries
    setA(1'b1, 5'd4, 32'hF1);
    setB(1'b1, 5'd11, 32'hE1);
    expectWrite(5'd4, 32'hF1);
    step();
    setA(1'b1, 5'd4, 32'hF2);
    setB(1'b1, 5'd12, 32'hE2);
    step();
    check("prerst_cnt2", fifoCnt, 2);
    rst_n = 1'b0;
    #1;
    check("async_regWrite0", regWrite, 0);
    check("async_fifo_cnt0", fifoCnt, 0);
    check("async_b_ready1", bReady, 1);
    check("async_a_stall0", aStall, 0);
    check("async_err0", err, 0);
    setA(1'b0, 5'd0, 32'h0);
    setB(1'b0, 5'd0, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("rf4_keeps_F1", rf[4], 32'hF1);
    check("rf11_never_written", rf[11], 32'h0);
    check("queue_drained", 32'(expReg.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  end

endmodule
